// File: rtl/mouse_device_sm.sv
// -----------------------------------------------------------------------------
// mouse_device_sm
// Device-side PS/2 mouse protocol engine. It answers host commands with an
// acknowledge (or a resend request for corrupted bytes), runs the power-on /
// reset self-test sequence (delay, AA, 00), and, while data reporting is on,
// turns accumulated movement and button changes into 3-byte stream packets.
//
// Ports
//   CLK              sole clock, rising edge
//   RESET            synchronous, active-high reset
//   READ_ENABLE      receiver enable, low only while in reset
//   BYTE_READ        host command byte
//   BYTE_ERROR_CODE  receive status, 00 = good
//   BYTE_READY       one-cycle strobe, BYTE_READ/BYTE_ERROR_CODE valid
//   SEND_BYTE        one-cycle transmit request
//   BYTE_TO_SEND     byte to transmit, held until BYTE_SENT
//   BYTE_SENT        one-cycle strobe, transmit finished
//   MOVE_VALID       movement sample strobe
//   MOVE_DX/MOVE_DY  signed 9-bit movement deltas
//   BUTTONS          {middle, right, left} button levels
//   STREAMING        data reporting enabled
//   PACKET_DONE      one-cycle pulse after the last packet byte is sent
//
// Optional feature: define MOUSE_DEVICE_RESEND_EN to make host command FE
// retransmit the last byte sent (AA if nothing has been sent since reset).
// Without it FE is acknowledged like any other unknown command.
// -----------------------------------------------------------------------------
module mouse_device_sm #(
  parameter int BAT_DELAY = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  input  logic       MOVE_VALID,
  input  logic [8:0] MOVE_DX,
  input  logic [8:0] MOVE_DY,
  input  logic [2:0] BUTTONS,
  output logic       STREAMING,
  output logic       PACKET_DONE
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ACK_SEND  = 4'd1;
  localparam logic [3:0] ACK_WAIT  = 4'd2;
  localparam logic [3:0] BAT_DLY   = 4'd3;
  localparam logic [3:0] BAT_SEND  = 4'd4;
  localparam logic [3:0] BAT_WAIT  = 4'd5;
  localparam logic [3:0] ID_SEND   = 4'd6;
  localparam logic [3:0] ID_WAIT   = 4'd7;
  localparam logic [3:0] STAT_SEND = 4'd8;
  localparam logic [3:0] STAT_WAIT = 4'd9;
  localparam logic [3:0] DX_SEND   = 4'd10;
  localparam logic [3:0] DX_WAIT   = 4'd11;
  localparam logic [3:0] DY_SEND   = 4'd12;
  localparam logic [3:0] DY_WAIT   = 4'd13;

  // What to do once the acknowledge byte has gone out
  localparam logic [2:0] ACT_NONE = 3'd0;
  localparam logic [2:0] ACT_BAT  = 3'd1;
  localparam logic [2:0] ACT_ID   = 3'd2;
  localparam logic [2:0] ACT_ON   = 3'd3;
  localparam logic [2:0] ACT_OFF  = 3'd4;

  localparam logic [15:0] BAT_LAST = 16'(BAT_DELAY - 1);

  // Saturating signed add; result is {overflow, sum clamped to [-256, 255]}
  function automatic logic [9:0] sat_add(input logic [8:0] acc, input logic [8:0] delta);
    logic signed [9:0] sum;
    sum = $signed({acc[8], acc}) + $signed({delta[8], delta});
    if (sum > 10'sd255) begin
      sat_add = {1'b1, 9'h0FF};
    end else if (sum < -10'sd256) begin
      sat_add = {1'b1, 9'h100};
    end else begin
      sat_add = {1'b0, sum[8:0]};
    end
  endfunction

  logic [3:0]  state_r;
  logic [15:0] bat_cnt_r;
  logic        pend_valid_r, pend_err_r;
  logic [7:0]  pend_byte_r;
  logic [8:0]  acc_x_r, acc_y_r;
  logic        ovf_x_r, ovf_y_r;
  logic [2:0]  buttons_r, last_btn_r;
  logic [7:0]  dx_r, dy_r;
  logic [2:0]  ack_act_r;
  logic        read_enable_r, send_byte_r, streaming_r, packet_done_r;
  logic [7:0]  byte_to_send_r;
`ifdef MOUSE_DEVICE_RESEND_EN
  logic [7:0]  last_byte_r;
`endif

  logic        is_wait_s, take_cmd_s, start_pkt_s, clr_acc_s;
  logic [7:0]  cmd_byte_s, status_s;
  logic [2:0]  cmd_act_s;
  logic        cmd_reset_s;
  logic [8:0]  ax_base_s, ay_base_s, acc_x_nxt_s, acc_y_nxt_s;
  logic        ox_base_s, oy_base_s, ovf_x_nxt_s, ovf_y_nxt_s;
  logic [9:0]  sum_x_s, sum_y_s;

  // Scheduling: when a pending command is serviced and when a packet starts.
  // BUTTONS is sampled into buttons_r first so the packet-start decision and
  // the status byte both see the same registered button state.
  always_comb begin
    is_wait_s = (state_r == ACK_WAIT) || (state_r == BAT_WAIT) || (state_r == ID_WAIT) ||
                (state_r == STAT_WAIT) || (state_r == DX_WAIT) || (state_r == DY_WAIT);
    take_cmd_s = pend_valid_r && ((state_r == IDLE) || (is_wait_s && BYTE_SENT));
    start_pkt_s = (state_r == IDLE) && !pend_valid_r && streaming_r &&
                  ((acc_x_r != 9'd0) || (acc_y_r != 9'd0) || ovf_x_r || ovf_y_r ||
                   (buttons_r != last_btn_r));
    status_s = {ovf_y_r, ovf_x_r, acc_y_r[8], acc_x_r[8], 1'b1, buttons_r};
  end

  // Command decode: response byte and follow-up action for the pending entry
  always_comb begin
    cmd_byte_s  = 8'hFA;
    cmd_act_s   = ACT_NONE;
    cmd_reset_s = 1'b0;
    if (pend_err_r) begin
      cmd_byte_s = 8'hFE;
    end else begin
      case (pend_byte_r)
        8'hFF: begin
          cmd_act_s   = ACT_BAT;
          cmd_reset_s = 1'b1;
        end
        8'hF4: cmd_act_s = ACT_ON;
        8'hF5: cmd_act_s = ACT_OFF;
        8'hF2: cmd_act_s = ACT_ID;
`ifdef MOUSE_DEVICE_RESEND_EN
        8'hFE: cmd_byte_s = last_byte_r;
`endif
        default: cmd_act_s = ACT_NONE;
      endcase
    end
  end

  // Movement accumulation; a clear in the same cycle as a sample keeps the sample
  always_comb begin
    clr_acc_s = start_pkt_s || (take_cmd_s && cmd_reset_s);
    if (clr_acc_s) begin
      ax_base_s = 9'd0;
      ay_base_s = 9'd0;
      ox_base_s = 1'b0;
      oy_base_s = 1'b0;
    end else begin
      ax_base_s = acc_x_r;
      ay_base_s = acc_y_r;
      ox_base_s = ovf_x_r;
      oy_base_s = ovf_y_r;
    end
    sum_x_s = sat_add(ax_base_s, MOVE_DX);
    sum_y_s = sat_add(ay_base_s, MOVE_DY);
    if (MOVE_VALID) begin
      acc_x_nxt_s = sum_x_s[8:0];
      acc_y_nxt_s = sum_y_s[8:0];
      ovf_x_nxt_s = ox_base_s | sum_x_s[9];
      ovf_y_nxt_s = oy_base_s | sum_y_s[9];
    end else begin
      acc_x_nxt_s = ax_base_s;
      acc_y_nxt_s = ay_base_s;
      ovf_x_nxt_s = ox_base_s;
      ovf_y_nxt_s = oy_base_s;
    end
  end

  // Main state machine, command latch and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r        <= BAT_DLY;
      bat_cnt_r      <= 16'd0;
      pend_valid_r   <= 1'b0;
      pend_err_r     <= 1'b0;
      pend_byte_r    <= 8'h00;
      acc_x_r        <= 9'd0;
      acc_y_r        <= 9'd0;
      ovf_x_r        <= 1'b0;
      ovf_y_r        <= 1'b0;
      buttons_r      <= 3'd0;
      last_btn_r     <= 3'd0;
      dx_r           <= 8'h00;
      dy_r           <= 8'h00;
      ack_act_r      <= ACT_NONE;
      read_enable_r  <= 1'b0;
      send_byte_r    <= 1'b0;
      byte_to_send_r <= 8'h00;
      streaming_r    <= 1'b0;
      packet_done_r  <= 1'b0;
`ifdef MOUSE_DEVICE_RESEND_EN
      last_byte_r    <= 8'hAA;
`endif
    end else begin
      read_enable_r <= 1'b1;
      send_byte_r   <= 1'b0;
      packet_done_r <= 1'b0;
      buttons_r     <= BUTTONS;
      acc_x_r       <= acc_x_nxt_s;
      acc_y_r       <= acc_y_nxt_s;
      ovf_x_r       <= ovf_x_nxt_s;
      ovf_y_r       <= ovf_y_nxt_s;

      // A byte arriving in the same cycle as a service stays pending
      if (take_cmd_s) begin
        pend_valid_r <= 1'b0;
      end
      if (BYTE_READY) begin
        pend_valid_r <= 1'b1;
        pend_err_r   <= (BYTE_ERROR_CODE != 2'b00);
        pend_byte_r  <= (BYTE_ERROR_CODE != 2'b00) ? 8'hFE : BYTE_READ;
      end
`ifdef MOUSE_DEVICE_RESEND_EN
      if (is_wait_s && BYTE_SENT) begin
        last_byte_r <= byte_to_send_r;
      end
`endif

      case (state_r)
        IDLE: begin
          if (start_pkt_s) begin
            state_r        <= STAT_SEND;
            send_byte_r    <= 1'b1;
            byte_to_send_r <= status_s;
            dx_r           <= acc_x_r[7:0];
            dy_r           <= acc_y_r[7:0];
            last_btn_r     <= buttons_r;
          end
        end
        ACK_SEND: state_r <= ACK_WAIT;
        ACK_WAIT: begin
          if (BYTE_SENT) begin
            state_r <= IDLE;
            case (ack_act_r)
              ACT_BAT: begin
                state_r   <= BAT_DLY;
                bat_cnt_r <= 16'd0;
              end
              ACT_ID: begin
                state_r        <= ID_SEND;
                send_byte_r    <= 1'b1;
                byte_to_send_r <= 8'h00;
              end
              ACT_ON:  streaming_r <= 1'b1;
              ACT_OFF: streaming_r <= 1'b0;
              default: state_r <= IDLE;
            endcase
          end
        end
        BAT_DLY: begin
          if (bat_cnt_r == BAT_LAST) begin
            state_r        <= BAT_SEND;
            send_byte_r    <= 1'b1;
            byte_to_send_r <= 8'hAA;
          end else begin
            bat_cnt_r <= bat_cnt_r + 16'd1;
          end
        end
        BAT_SEND: state_r <= BAT_WAIT;
        BAT_WAIT: begin
          if (BYTE_SENT) begin
            state_r        <= ID_SEND;
            send_byte_r    <= 1'b1;
            byte_to_send_r <= 8'h00;
          end
        end
        ID_SEND: state_r <= ID_WAIT;
        ID_WAIT: begin
          if (BYTE_SENT) begin
            state_r <= IDLE;
          end
        end
        STAT_SEND: state_r <= STAT_WAIT;
        STAT_WAIT: begin
          if (BYTE_SENT) begin
            state_r        <= DX_SEND;
            send_byte_r    <= 1'b1;
            byte_to_send_r <= dx_r;
          end
        end
        DX_SEND: state_r <= DX_WAIT;
        DX_WAIT: begin
          if (BYTE_SENT) begin
            state_r        <= DY_SEND;
            send_byte_r    <= 1'b1;
            byte_to_send_r <= dy_r;
          end
        end
        DY_SEND: state_r <= DY_WAIT;
        DY_WAIT: begin
          if (BYTE_SENT) begin
            state_r       <= IDLE;
            packet_done_r <= 1'b1;
          end
        end
        default: state_r <= IDLE;
      endcase

      // Servicing a command overrides the normal next step, aborting any
      // remaining packet bytes; a completed ack's streaming change still lands
      if (take_cmd_s) begin
        state_r        <= ACK_SEND;
        send_byte_r    <= 1'b1;
        byte_to_send_r <= cmd_byte_s;
        ack_act_r      <= cmd_act_s;
        if (cmd_reset_s) begin
          streaming_r <= 1'b0;
        end
      end
    end
  end

  assign READ_ENABLE  = read_enable_r;
  assign SEND_BYTE    = send_byte_r;
  assign BYTE_TO_SEND = byte_to_send_r;
  assign STREAMING    = streaming_r;
  assign PACKET_DONE  = packet_done_r;

endmodule

// File: tb/tb_mouse_device_sm.sv
// -----------------------------------------------------------------------------
// tb_mouse_device_sm
// Directed bench for mouse_device_sm with BAT_DELAY = 8. Expected transmit
// bytes are queued as each stimulus is applied and popped when the device
// raises SEND_BYTE; the bench plays the host side of the link.
// -----------------------------------------------------------------------------
module tb_mouse_device_sm;

  localparam int BD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       read_enable;
  logic [7:0] byte_read;
  logic [1:0] byte_error_code;
  logic       byte_ready;
  logic       send_byte;
  logic [7:0] byte_to_send;
  logic       byte_sent;
  logic       move_valid;
  logic [8:0] move_dx, move_dy;
  logic [2:0] buttons;
  logic       streaming;
  logic       packet_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  mouse_device_sm #(.BAT_DELAY(BD)) dut (
    .CLK(clk), .RESET(reset), .READ_ENABLE(read_enable),
    .BYTE_READ(byte_read), .BYTE_ERROR_CODE(byte_error_code), .BYTE_READY(byte_ready),
    .SEND_BYTE(send_byte), .BYTE_TO_SEND(byte_to_send), .BYTE_SENT(byte_sent),
    .MOVE_VALID(move_valid), .MOVE_DX(move_dx), .MOVE_DY(move_dy),
    .BUTTONS(buttons), .STREAMING(streaming), .PACKET_DONE(packet_done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_cmd(input logic [7:0] b, input logic [1:0] code);
    byte_read = b; byte_error_code = code; byte_ready = 1'b1;
    @(negedge clk);
    byte_ready = 1'b0;
  endtask

  // Waits (bounded) for SEND_BYTE; gap = negedges waited
  task automatic wait_send(output logic [7:0] b, output int gap);
    gap = 0;
    while (!send_byte && gap < 400) begin
      @(negedge clk);
      gap++;
    end
    if (!send_byte) check("send_timeout", {15'd0, send_byte}, 16'd1);
    b = byte_to_send;
  endtask

  // Host side of one transmit. mode 1: host sends FF while the byte is in
  // flight; mode 2: three +200 X moves with BUTTONS=100 while in flight.
  task automatic serve(input string tag, input int mode, output int gap);
    logic [7:0] b, e;
    wait_send(b, gap);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check(tag, {8'd0, b}, {8'd0, e});
    @(negedge clk);
    check({tag, "_pulse"}, {15'd0, send_byte}, 16'd0);
    if (mode == 1) begin
      host_cmd(8'hFF, 2'b00);
    end else if (mode == 2) begin
      buttons = 3'b100;
      for (int i = 0; i < 3; i++) begin
        move_valid = 1'b1; move_dx = 9'h0C8; move_dy = 9'h000;
        @(negedge clk);
      end
      move_valid = 1'b0;
    end else begin
      @(negedge clk);
    end
    check({tag, "_hold"}, {8'd0, byte_to_send}, {8'd0, e});
    byte_sent = 1'b1;
    @(negedge clk);
    byte_sent = 1'b0;
  endtask

  initial begin
    int gap;
    logic [7:0] b;
    reset = 1'b1; byte_read = 8'h00; byte_error_code = 2'b00; byte_ready = 1'b0;
    byte_sent = 1'b0; move_valid = 1'b0; move_dx = 9'd0; move_dy = 9'd0; buttons = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_read_en", {15'd0, read_enable}, 16'd0);
    check("rst_send", {15'd0, send_byte}, 16'd0);
    check("rst_byte", {8'd0, byte_to_send}, 16'd0);
    check("rst_stream", {15'd0, streaming}, 16'd0);
    check("rst_pdone", {15'd0, packet_done}, 16'd0);

    // Power-on: BD cycles of silence, then AA, 00
    reset = 1'b0;
    exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
    serve("bat_aa", 0, gap);
    check("bat_gap", 16'(gap), 16'(BD));
    serve("bat_id", 0, gap);
    check("por_read_en", {15'd0, read_enable}, 16'd1);
    check("por_stream", {15'd0, streaming}, 16'd0);

    // Enable streaming, then one movement sample with left button
    host_cmd(8'hF4, 2'b00);
    exp_q.push_back(8'hFA);
    serve("f4_ack", 0, gap);
    check("f4_stream", {15'd0, streaming}, 16'd1);
    buttons = 3'b001; move_valid = 1'b1; move_dx = 9'd5; move_dy = 9'h1FD;
    exp_q.push_back(8'h29); exp_q.push_back(8'h05); exp_q.push_back(8'hFD);
    @(negedge clk);
    move_valid = 1'b0;
    serve("pkt1_stat", 0, gap);
    serve("pkt1_dx", 0, gap);
    check("pkt1_early_done", {15'd0, packet_done}, 16'd0);
    serve("pkt1_dy", 0, gap);
    check("pkt1_done", {15'd0, packet_done}, 16'd1);
    @(negedge clk);
    check("pkt1_done_pulse", {15'd0, packet_done}, 16'd0);

    // Saturation: three +200 X moves accumulated while an ack is in flight
    host_cmd(8'hF4, 2'b00);
    exp_q.push_back(8'hFA);
    exp_q.push_back(8'h4C); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    serve("sat_ack", 2, gap);
    serve("sat_stat", 0, gap);
    serve("sat_dx", 0, gap);
    serve("sat_dy", 0, gap);
    check("sat_done", {15'd0, packet_done}, 16'd1);

    // Corrupted host byte -> resend request, streaming untouched
    host_cmd(8'hF5, 2'b01);
    exp_q.push_back(8'hFE);
    serve("err_fe", 0, gap);
    repeat (2) @(negedge clk);
    check("err_stream", {15'd0, streaming}, 16'd1);
    check("err_quiet", {15'd0, send_byte}, 16'd0);

    // Host reset arriving while DX is in flight aborts the packet
    move_valid = 1'b1; move_dx = 9'd1; move_dy = 9'd0;
    @(negedge clk);
    move_valid = 1'b0;
    exp_q.push_back(8'h0C); exp_q.push_back(8'h01);
    exp_q.push_back(8'hFA); exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
    serve("abort_stat", 0, gap);
    serve("abort_dx", 1, gap);
    check("abort_no_done", {15'd0, packet_done}, 16'd0);
    serve("abort_ack", 0, gap);
    check("abort_stream_off", {15'd0, streaming}, 16'd0);
    serve("abort_aa", 0, gap);
    check("abort_bat_gap", 16'(gap), 16'(BD));
    serve("abort_id", 0, gap);
    check("abort_stream", {15'd0, streaming}, 16'd0);

    // Get ID then resend request
    host_cmd(8'hF2, 2'b00);
    exp_q.push_back(8'hFA); exp_q.push_back(8'h00);
    serve("id_ack", 0, gap);
    serve("id_byte", 0, gap);
    host_cmd(8'hFE, 2'b00);
`ifdef MOUSE_DEVICE_RESEND_EN
    exp_q.push_back(8'h00);
`else
    exp_q.push_back(8'hFA);
`endif
    serve("resend", 0, gap);

    // Reset in the middle of a transfer
    host_cmd(8'hF4, 2'b00);
    exp_q.push_back(8'hFA);
    wait_send(b, gap);
    check("mid_fa", {8'd0, b}, {8'd0, exp_q.pop_front()});
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_send", {15'd0, send_byte}, 16'd0);
    check("mid_rst_read_en", {15'd0, read_enable}, 16'd0);
    check("mid_rst_byte", {8'd0, byte_to_send}, 16'd0);
    byte_sent = 1'b1;
    @(negedge clk);
    byte_sent = 1'b0;
    reset = 1'b0;
    exp_q.push_back(8'hAA); exp_q.push_back(8'h00);
    serve("mid_aa", 0, gap);
    check("mid_bat_gap", 16'(gap), 16'(BD));
    serve("mid_id", 0, gap);
    check("mid_stream", {15'd0, streaming}, 16'd0);
    check("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mouse_device_sm.md
MOUSE_DEVICE_SM -- requirements
Module: mouse_device_sm

Interface
REQ-001 Parameter BAT_DELAY, default 1000, clock cycles from the FA reset ack to the AA self-test byte (legal range 1..65535).
REQ-002 Port CLK, in, 1: sole clock, rising edge.
REQ-003 Port RESET, in, 1: synchronous, active-high reset.
REQ-004 Port READ_ENABLE, out, 1: receiver enable toward the PS/2 byte receiver.
REQ-005 Port BYTE_READ, in, 8: host command byte.
REQ-006 Port BYTE_ERROR_CODE, in, 2: receive error, 00 = good.
REQ-007 Port BYTE_READY, in, 1: one-cycle pulse, byte valid.
REQ-008 Port SEND_BYTE, out, 1: one-cycle transmit request.
REQ-009 Port BYTE_TO_SEND, out, 8: byte to transmit, held until BYTE_SENT.
REQ-010 Port BYTE_SENT, in, 1: one-cycle pulse, transmit complete.
REQ-011 Port MOVE_VALID, in, 1: movement sample strobe.
REQ-012 Ports MOVE_DX and MOVE_DY, in, 9 each: signed two's-complement deltas.
REQ-013 Port BUTTONS, in, 3: {middle, right, left}, level.
REQ-014 Port STREAMING, out, 1: data reporting enabled.
REQ-015 Port PACKET_DONE, out, 1: one-cycle pulse after the DY byte's BYTE_SENT.

Function
REQ-016 READ_ENABLE SHALL be 1 in every cycle except while RESET is high.
REQ-017 Byte transmit SHALL be handled by a SEND/WAIT state pair:
- SEND asserts SEND_BYTE for exactly 1 cycle with BYTE_TO_SEND valid in that cycle.
- WAIT holds BYTE_TO_SEND until BYTE_SENT.
REQ-018 States SHALL be IDLE, ACK_SEND/WAIT, BAT_DLY, BAT_SEND/WAIT, ID_SEND/WAIT, STAT_SEND/WAIT, DX_SEND/WAIT, DY_SEND/WAIT.
REQ-019 A BYTE_READY with BYTE_ERROR_CODE != 00 SHALL load pending response FE (resend request); the command SHALL be otherwise ignored.
REQ-020 Good commands SHALL be latched into a one-deep pending register; a newer command overwrites an unprocessed one.
REQ-021 Pending commands SHALL be processed only in IDLE or on BYTE_SENT in any WAIT state; processing aborts any remaining packet bytes.
REQ-022 Command FF: send FA, clear STREAMING and accumulators, BAT_DLY for BAT_DELAY cycles, send AA, send 00, then IDLE.
REQ-023 Command F4: send FA, then set STREAMING=1. Command F5: send FA, then set STREAMING=0.
REQ-024 Command F2: send FA, then send 00.
REQ-025 Any other command: send FA, no other effect, except FE when RESEND_EN is defined (REQ-035).
REQ-026 Accumulators accX and accY SHALL be 9-bit signed.
- On MOVE_VALID, add the delta and saturate to [-256, +255].
- Set sticky ovfX/ovfY when saturation occurs.
- Accumulate regardless of state and of STREAMING.
REQ-027 Packet start SHALL occur in IDLE, with no pending command and STREAMING=1, when accX!=0, accY!=0, ovf set, or BUTTONS differs from the last-reported buttons.
REQ-028 At packet start the block SHALL snapshot the status, DX and DY bytes, and clear accumulators and ovf. A MOVE_VALID in the same cycle adds into the cleared accumulators.
REQ-029 Status byte SHALL be {ovfY, ovfX, accY[8], accX[8], 1, BUTTONS[2:0]}; DX = accX[7:0]; DY = accY[7:0].
REQ-030 Bytes SHALL be sent status, DX, DY, each as a SEND/WAIT pair; PACKET_DONE pulses in the cycle after the DY byte's BYTE_SENT; then IDLE.
REQ-031 Idle-to-SEND_BYTE latency SHALL be 1 cycle after the triggering event is registered.

Reset
REQ-032 While RESET is high, all outputs SHALL be 0, accumulators, ovf, pending register and last-reported buttons cleared, and state BAT_DLY.
REQ-033 After RESET falls, the block SHALL run the power-on sequence: BAT_DELAY cycles, AA, 00, then IDLE with STREAMING=0.
REQ-034 RESET asserted mid-transfer SHALL abandon the byte with no further SEND_BYTE.

Configuration
REQ-035 With macro MOUSE_DEVICE_RESEND_EN defined, command FE SHALL retransmit the last byte sent (no FA); if no byte has been sent since reset, it retransmits AA.
REQ-036 Without MOUSE_DEVICE_RESEND_EN, FE SHALL be handled per REQ-025, and the last-byte register SHALL not exist.

Verification
REQ-037 Release reset, BAT_DELAY=8 -> no SEND_BYTE for 8 cycles, then AA, then 00; STREAMING=0.
REQ-038 Host F4 -> FA sent, STREAMING=1; then MOVE_VALID dx=+5, dy=-3, BUTTONS=001 -> bytes 29, 05, FD, then PACKET_DONE pulse.
REQ-039 Streaming on, three MOVE_VALID dx=+200 each -> status 4C, DX FF (saturated at +255, ovfX=1).
REQ-040 BYTE_READY with error code 01 -> FE sent, state otherwise unchanged.
REQ-041 Host FF received during a packet's DX byte -> DY byte never sent; FA, BAT_DELAY gap, AA, 00 follow; STREAMING=0.
REQ-042 With MOUSE_DEVICE_RESEND_EN, FE after F2/00 sequence -> 00 retransmitted; without the macro -> FA sent.
